// File: rtl/depth_upscale_2x.sv
// Nearest-neighbour 2x upscaler for a single-channel depth stream.
// Each accepted pixel is emitted twice (live copy plus its duplicate slot).
// The row is then replayed from a line buffer, again with each pixel doubled.
// A WxH input becomes a 2Wx2H output with sop/eop/sof/eof framing.
// After an eop pixel the block is ready for the next sop 2W+2 cycles later.
module depth_upscale_2x #(
  parameter  int DATA_WIDTH = 8,
  parameter  int LINE_LEN   = 112,
  localparam int ADDR_W     = $clog2(LINE_LEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  input  logic                  sof_i,
  input  logic                  eof_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  err_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  // LIVE waits for a pixel, DUP is the duplicate slot, REPLAY reads the buffer
  typedef enum logic [1:0] {S_IDLE, S_LIVE, S_DUP, S_REPLAY} state_t;

  state_t                state, nxt_state;
  logic [ADDR_W-1:0]     wr_addr, nxt_wr_addr;
  logic                  full, nxt_full;          // buffer holds LINE_LEN pixels
  logic [ADDR_W-1:0]     last_addr, nxt_last_addr; // W-1 of the row to replay
  logic                  eof_lat, nxt_eof_lat;
  logic                  dup_eop, nxt_dup_eop;     // duplicate slot carries eop
  logic [ADDR_W-1:0]     out_pix, nxt_out_pix;     // replay pixel index
  logic                  phase, nxt_phase;         // 0: first copy, 1: second copy
  logic                  nxt_err;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic                  nxt_valid, nxt_sop, nxt_eop, nxt_sof, nxt_eof;

  logic                  take;
  logic [ADDR_W-1:0]     take_addr;
  logic                  wr_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  replay_last;

  logic [DATA_WIDTH-1:0] mem [LINE_LEN];
  logic [DATA_WIDTH-1:0] ram_q;

  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? a : a + ONE;
  endfunction

  // Line buffer: write on accepted pixels, registered read every cycle
  // NOTE: the buffer holds only data, so it has no reset; readers never see
  // an address that was not written in the current row.
  always_ff @(posedge clk) begin
    if (wr_en) mem[take_addr] <= data_i;
    ram_q <= mem[rd_addr];
  end

  // Next-state and next-output decode
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    nxt_state     = state;
    nxt_wr_addr   = wr_addr;
    nxt_full      = full;
    nxt_last_addr = last_addr;
    nxt_eof_lat   = eof_lat;
    nxt_dup_eop   = dup_eop;
    nxt_out_pix   = out_pix;
    nxt_phase     = phase;
    nxt_err       = err_o;
    nxt_data      = '0;
    nxt_valid     = 1'b0;
    nxt_sop       = 1'b0;
    nxt_eop       = 1'b0;
    nxt_sof       = 1'b0;
    nxt_eof       = 1'b0;
    take          = 1'b0;
    take_addr     = '0;
    wr_en         = 1'b0;
    rd_addr       = '0;   // outside REPLAY this pre-fetches pixel 0
    replay_last   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (data_valid_i && sop_i) take = 1'b1;
      end
      S_LIVE: begin
        if (data_valid_i) begin
          if (sop_i) begin
            // row abandoned: restart at address 0
            nxt_err = 1'b1;
            take    = 1'b1;
          end else if (!full) begin
            take      = 1'b1;
            take_addr = wr_addr;
          end else begin
            // excess pixel: not stored, not emitted; eop still closes the row
            nxt_err = 1'b1;
            if (eop_i) begin
              nxt_last_addr = wr_addr;
              nxt_eof_lat   = eof_i;
              nxt_out_pix   = '0;
              nxt_phase     = 1'b0;
              nxt_state     = S_REPLAY;
            end
          end
        end
      end
      S_DUP: begin
        nxt_valid = 1'b1;
        nxt_data  = data_o;
        nxt_eop   = dup_eop;
        if (data_valid_i) nxt_err = 1'b1;
        if (dup_eop) begin
          nxt_out_pix = '0;
          nxt_phase   = 1'b0;
          nxt_state   = S_REPLAY;
        end else begin
          nxt_state = S_LIVE;
        end
      end
      S_REPLAY: begin
        replay_last = phase && (out_pix == last_addr);
        nxt_valid   = 1'b1;
        nxt_data    = ram_q;
        nxt_sop     = !phase && (out_pix == '0);
        nxt_eop     = replay_last;
        nxt_eof     = replay_last && eof_lat;
        // fetch the next pixel during the second copy of the current one
        rd_addr     = (phase && out_pix != LAST_ADDR) ? out_pix + ONE : out_pix;
        nxt_phase   = !phase;
        if (phase) nxt_out_pix = sat_inc(out_pix);
        if (data_valid_i) nxt_err = 1'b1;
        if (replay_last) begin
          nxt_wr_addr = '0;
          nxt_full    = 1'b0;
          nxt_state   = S_IDLE;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    if (take) begin
      wr_en       = 1'b1;
      nxt_wr_addr = sat_inc(take_addr);
      nxt_full    = (take_addr == LAST_ADDR);
      nxt_valid   = 1'b1;
      nxt_data    = data_i;
      nxt_sop     = sop_i;
      nxt_sof     = sop_i && sof_i;
      nxt_dup_eop = eop_i;
      nxt_state   = S_DUP;
      if (eop_i) begin
        nxt_last_addr = take_addr;
        nxt_eof_lat   = eof_i;
      end
    end
  end

  // State and registered outputs
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      wr_addr      <= '0;
      full         <= 1'b0;
      last_addr    <= '0;
      eof_lat      <= 1'b0;
      dup_eop      <= 1'b0;
      out_pix      <= '0;
      phase        <= 1'b0;
      err_o        <= 1'b0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      sop_o        <= 1'b0;
      eop_o        <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
    end else begin
      state        <= nxt_state;
      wr_addr      <= nxt_wr_addr;
      full         <= nxt_full;
      last_addr    <= nxt_last_addr;
      eof_lat      <= nxt_eof_lat;
      dup_eop      <= nxt_dup_eop;
      out_pix      <= nxt_out_pix;
      phase        <= nxt_phase;
      err_o        <= nxt_err;
      data_o       <= nxt_data;
      data_valid_o <= nxt_valid;
      sop_o        <= nxt_sop;
      eop_o        <= nxt_eop;
      sof_o        <= nxt_sof;
      eof_o        <= nxt_eof;
    end
  end

endmodule
